// File: rtl/hqm_rcfwl_gclk_mc_sync_rcv.sv
// MC-side PLL sync receiver: synchronizes the distributed sync level, qualifies its period,
// locks a flywheel onto it and regenerates a clean sync pulse, phase and error reporting.
module hqm_rcfwl_gclk_mc_sync_rcv #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD      = 16,
    parameter int PERIOD_W    = 8,
    parameter int LOCK_CNT    = 3,
    parameter int LOSS_CNT    = 2
) (
    input  logic                mcckpredop,
    input  logic                mc_rst,
    input  logic                mc_pll_sync_in,
    input  logic                cfg_en,
    output logic                locked,
    output logic                sync_pulse,
    output logic [PERIOD_W-1:0] phase,
    output logic                sync_err,
    output logic [7:0]          err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);
    localparam logic [PERIOD_W-1:0] CNT_LAST  = PERIOD_W'(PERIOD - 1);
    localparam logic [GOOD_W-1:0]   GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]    BAD_LAST  = BAD_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_hist;
    logic                   edge_det;
    logic [PERIOD_W-1:0]    cnt;
    logic                   first;
    logic [GOOD_W-1:0]      good_cnt;
    logic [BAD_W-1:0]       bad_cnt;

    // sync_q[0] is the metastability-exposed stage; the last stage feeds edge detection.
    always_ff @(posedge mcckpredop or posedge mc_rst) begin
        if (mc_rst) begin
            sync_q    <= '0;
            sync_hist <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], mc_pll_sync_in};
            sync_hist <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_hist;

    always_ff @(posedge mcckpredop or posedge mc_rst) begin
        if (mc_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            first    <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            sync_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            sync_err <= 1'b0;
            if (!cfg_en) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                first    <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_ACQ;
                        cnt      <= '0;
                        first    <= 1'b0;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                    ST_ACQ: begin
                        if (edge_det) begin
                            // Every edge restarts the count and becomes the new reference.
                            cnt   <= '0;
                            first <= 1'b1;
                            if (first && cnt == CNT_LAST) begin
                                if (good_cnt == GOOD_LAST) begin
                                    state    <= ST_LOCKED;
                                    good_cnt <= '0;
                                    bad_cnt  <= '0;
                                end else begin
                                    good_cnt <= good_cnt + GOOD_W'(1);
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end else begin
                            if (cnt != '1)
                                cnt <= cnt + PERIOD_W'(1);
                            if (cnt == CNT_LAST) begin
                                first    <= 1'b0;
                                good_cnt <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + PERIOD_W'(1);
                        // Bad: an edge off the expected slot, or the expected slot without an edge.
                        if (edge_det != (cnt == CNT_LAST)) begin
                            sync_err <= 1'b1;
                            if (err_cnt != 8'hff)
                                err_cnt <= err_cnt + 8'd1;
                            if (bad_cnt == BAD_LAST) begin
                                state    <= ST_ACQ;
                                cnt      <= '0;
                                first    <= 1'b0;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + BAD_W'(1);
                            end
                        end else if (edge_det) begin
                            bad_cnt <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign locked     = (state == ST_LOCKED);
    assign sync_pulse = locked & (cnt == '0);
    assign phase      = locked ? cnt : '0;

endmodule
